// File: rtl/bitbang_link_ctrl.sv
// rtl/bitbang_link_ctrl.sv - bit-banged host link: work frame receiver and golden-nonce transmitter
//
// Purpose: receives 64-byte work frames over a strobed serial link, commits
// them as midstate/data on a frame strobe, and streams winning nonces back to
// the host through a small FIFO using a flag-then-8-bits protocol per byte.
//
// Ports:
//   clk, rst              system clock, async active-high reset
//   RxD, RxC              host serial data and its receive strobe (async)
//   RxTxR                 host frame strobe (async); rising edge ends a frame
//   TxC, TxD              host transmit strobe (async) and registered result data
//   golden_valid/_nonce   winning nonce report from the hasher
//   work_midstate/_data   committed work, work_load pulses on commit
//   nonce_count           golden-nonce FIFO occupancy
//   rx_overrun            sticky: a frame exceeded 64 bytes
//   nonce_dropped         sticky: a nonce was lost to a full FIFO
module bitbang_link_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RxD,
  input  logic                          RxC,
  input  logic                          RxTxR,
  input  logic                          TxC,
  output logic                          TxD,
  input  logic                          golden_valid,
  input  logic [31:0]                   golden_nonce,
  output logic [255:0]                  work_midstate,
  output logic [255:0]                  work_data,
  output logic                          work_load,
  output logic [$clog2(FIFO_DEPTH):0]   nonce_count,
  output logic                          rx_overrun,
  output logic                          nonce_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- sync
  // All four host lines share one chain so RxD sees exactly the RxC delay.
  // Bit order: {RxD, RxTxR, TxC, RxC}.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic       rxc_evt, txc_evt, rxtxr_evt, rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {RxD, RxTxR, TxC, RxC};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1][2:0];
    end
  end

  assign rxc_evt   = sync_q[SYNC_STAGES-1][0] & ~prev_q[0];
  assign txc_evt   = sync_q[SYNC_STAGES-1][1] & ~prev_q[1];
  assign rxtxr_evt = sync_q[SYNC_STAGES-1][2] & ~prev_q[2];
  assign rxd_s     = sync_q[SYNC_STAGES-1][3];

  // ------------------------------------------------------------- receive
  logic [7:0]   rx_byte_q, rx_byte_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   byte_cnt_q, byte_cnt_d;
  logic [511:0] frame_q, frame_d;
  logic         frame_ovr_q, frame_ovr_d;
  logic         rx_overrun_q, rx_overrun_d;
  logic [255:0] work_mid_q, work_mid_d, work_data_q, work_data_d;
  logic         work_load_q, work_load_d;

  always_comb begin
    rx_byte_d    = rx_byte_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    frame_d      = frame_q;
    frame_ovr_d  = frame_ovr_q;
    rx_overrun_d = rx_overrun_q;
    work_mid_d   = work_mid_q;
    work_data_d  = work_data_q;
    work_load_d  = 1'b0;
    // A frame strobe wins over a coincident data strobe; the bit is dropped.
    if (rxtxr_evt) begin
      if (byte_cnt_q == 7'd64 && bit_cnt_q == 3'd0 && !frame_ovr_q) begin
        work_mid_d  = frame_q[511:256];
        work_data_d = frame_q[255:0];
        work_load_d = 1'b1;
      end
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      frame_ovr_d = 1'b0;
    end else if (rxc_evt) begin
      if (byte_cnt_q == 7'd64) begin
        frame_ovr_d  = 1'b1;
        rx_overrun_d = 1'b1;
      end else begin
        rx_byte_d = {rxd_s, rx_byte_q[7:1]};
        if (bit_cnt_q == 3'd7) begin
          frame_d    = {frame_q[503:0], rxd_s, rx_byte_q[7:1]};
          byte_cnt_d = byte_cnt_q + 7'd1;
        end
        bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after the eighth bit
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_q    <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      frame_q      <= '0;
      frame_ovr_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      work_mid_q   <= '0;
      work_data_q  <= '0;
      work_load_q  <= 1'b0;
    end else begin
      rx_byte_q    <= rx_byte_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_q      <= frame_d;
      frame_ovr_q  <= frame_ovr_d;
      rx_overrun_q <= rx_overrun_d;
      work_mid_q   <= work_mid_d;
      work_data_q  <= work_data_d;
      work_load_q  <= work_load_d;
    end
  end

  // ---------------------------------------------------------------- fifo
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, fifo_cnt;
  logic        fifo_empty, fifo_full, push_ok, pop;
  logic        dropped_q;

  assign fifo_cnt   = wr_q - rd_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  // Full is fine when the head leaves in the same cycle.
  assign push_ok    = golden_valid & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_q[AW-1:0]] <= golden_nonce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (golden_valid && !push_ok) dropped_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------ transmit
  typedef enum logic {FLAG, BITS} tx_state_e;
  tx_state_e   state_q, state_d;
  logic        txd_q, txd_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] tx_nonce_q, tx_nonce_d, tx_shift;
  logic        tx_pending;

  // The head stays in the FIFO until its last bit, so a nonzero byte index
  // marks a nonce in flight; later bytes come from the private copy.
  assign tx_pending = (byte_idx_q != 2'd0) | ~fifo_empty;
  assign tx_shift   = tx_nonce_q << {byte_idx_q, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FLAG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (txc_evt) begin
      case (state_q)
        FLAG:    if (tx_pending) state_d = BITS;
        BITS:    if (bit_idx_q == 3'd7) state_d = FLAG;
        default: state_d = FLAG;
      endcase
    end
  end

  always_comb begin
    txd_d      = txd_q;
    tx_byte_d  = tx_byte_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_nonce_d = tx_nonce_q;
    pop        = 1'b0;
    if (txc_evt) begin
      case (state_q)
        FLAG: begin
          if (tx_pending) begin
            txd_d     = 1'b1;
            bit_idx_d = '0;
            if (byte_idx_q == 2'd0) begin
              tx_nonce_d = fifo_mem[rd_q[AW-1:0]];
              tx_byte_d  = fifo_mem[rd_q[AW-1:0]][31:24];
            end else begin
              tx_byte_d = tx_shift[31:24];
            end
          end else begin
            txd_d = 1'b0;
          end
        end
        BITS: begin
          txd_d     = tx_byte_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            byte_idx_d = byte_idx_q + 2'd1;
            pop        = (byte_idx_q == 2'd3);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_q      <= 1'b0;
      tx_byte_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_nonce_q <= '0;
    end else begin
      txd_q      <= txd_d;
      tx_byte_q  <= tx_byte_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_nonce_q <= tx_nonce_d;
    end
  end

  // ------------------------------------------------------------- outputs
  assign TxD           = txd_q;
  assign work_midstate = work_mid_q;
  assign work_data     = work_data_q;
  assign work_load     = work_load_q;
  assign nonce_count   = fifo_cnt;
  assign rx_overrun    = rx_overrun_q;
  assign nonce_dropped = dropped_q;

endmodule

// File: tb/tb_bitbang_link_ctrl.sv
// tb/tb_bitbang_link_ctrl.sv - scoreboard bench for bitbang_link_ctrl
module tb_bitbang_link_ctrl;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0, rst = 1'b1;
  logic         rxd = 1'b0, rxc = 1'b0, rxtxr = 1'b0, txc = 1'b0;
  logic         golden_valid = 1'b0;
  logic [31:0]  golden_nonce = '0;
  logic         txd, work_load, rx_overrun, nonce_dropped;
  logic [255:0] work_midstate, work_data;
  logic [2:0]   nonce_count;

  bitbang_link_ctrl #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .RxD(rxd), .RxC(rxc), .RxTxR(rxtxr), .TxC(txc), .TxD(txd),
    .golden_valid(golden_valid), .golden_nonce(golden_nonce),
    .work_midstate(work_midstate), .work_data(work_data), .work_load(work_load),
    .nonce_count(nonce_count), .rx_overrun(rx_overrun), .nonce_dropped(nonce_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]   f_bytes[$];
  logic [7:0]   part_byte;
  int           part_bits;
  bit           f_ovr, m_overrun, m_dropped;
  logic [255:0] m_mid, m_data;
  logic [31:0]  m_fifo[$];
  bit           cur_bits[$];
  // scoreboards
  bit           exp_tx[$];
  logic [255:0] exp_mid[$], exp_data[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // work monitor
  always @(negedge clk) begin
    if (!rst && work_load === 1'b1) begin
      if (exp_mid.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL work_load_unexpected: got 1, expected 0");
      end else begin
        logic [255:0] em, ed;
        em = exp_mid.pop_front();
        ed = exp_data.pop_front();
        check("work_midstate", work_midstate, em);
        check("work_data", work_data, ed);
      end
    end
  end

  // transmit monitor: each host poll completes on the falling TxC
  always @(negedge txc) begin
    if (exp_tx.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL txd_unexpected_poll: got %b, expected none", txd);
    end else begin
      bit e;
      e = exp_tx.pop_front();
      check("txd_bit", {255'd0, txd}, {255'd0, e});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    f_bytes.delete(); part_bits = 0; part_byte = '0; f_ovr = 0;
    m_overrun = 0; m_dropped = 0; m_mid = '0; m_data = '0;
    m_fifo.delete(); cur_bits.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic send_bit(input bit b);
    if (f_bytes.size() == 64) begin
      f_ovr = 1; m_overrun = 1;
    end else begin
      part_byte[part_bits] = b;
      part_bits++;
      if (part_bits == 8) begin f_bytes.push_back(part_byte); part_bits = 0; end
    end
    @(negedge clk); rxd = b;
    @(negedge clk); rxc = 1'b1;
    idle(S + 1);
    rxc = 1'b0;
    idle(S + 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_random_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic frame_strobe();
    if (f_bytes.size() == 64 && part_bits == 0 && !f_ovr) begin
      for (int i = 0; i < 32; i++) begin
        m_mid[255-8*i -: 8]  = f_bytes[i];
        m_data[255-8*i -: 8] = f_bytes[32+i];
      end
      exp_mid.push_back(m_mid);
      exp_data.push_back(m_data);
    end
    f_bytes.delete(); part_bits = 0; f_ovr = 0;
    @(negedge clk); rxtxr = 1'b1;
    idle(S + 2);
    rxtxr = 1'b0;
    idle(S + 4);
  endtask

  task automatic model_push(input logic [31:0] n);
    if (m_fifo.size() < D) m_fifo.push_back(n);
    else m_dropped = 1;
  endtask

  task automatic push_nonce(input logic [31:0] n);
    @(negedge clk);
    golden_valid = 1'b1; golden_nonce = n;
    model_push(n);
    @(negedge clk);
    golden_valid = 1'b0;
  endtask

  // One host poll; optionally a nonce arrives on the cycle the poll is acted on.
  task automatic poll(input bit with_push, input logic [31:0] n);
    bit e;
    logic [7:0] b;
    if (cur_bits.size() == 0 && m_fifo.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        b = m_fifo[0][31-8*k -: 8];
        cur_bits.push_back(1'b1);
        for (int i = 0; i < 8; i++) cur_bits.push_back(b[i]);
      end
    end
    if (cur_bits.size() > 0) begin
      e = cur_bits.pop_front();
      if (cur_bits.size() == 0) void'(m_fifo.pop_front());
    end else begin
      e = 1'b0;
    end
    exp_tx.push_back(e);
    @(negedge clk); txc = 1'b1;
    idle(S);
    if (with_push) begin
      golden_valid = 1'b1; golden_nonce = n;
      model_push(n);
    end
    idle(1);
    golden_valid = 1'b0;
    idle(1);
    txc = 1'b0;
    idle(S + 2);
  endtask

  task automatic polls(input int n);
    for (int i = 0; i < n; i++) poll(1'b0, '0);
  endtask

  task automatic check_status(input string tag);
    idle(4);
    check({tag, "_nonce_count"}, {253'd0, nonce_count}, 256'(m_fifo.size()));
    check({tag, "_rx_overrun"}, {255'd0, rx_overrun}, {255'd0, m_overrun});
    check({tag, "_nonce_dropped"}, {255'd0, nonce_dropped}, {255'd0, m_dropped});
  endtask

  initial begin
    logic [255:0] c_mid, c_data;
    logic [31:0]  c_nonce;
    c_mid   = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
    c_data  = 256'h00000000000000000000000080000000000000002194261a9395e64dbed17115;
    c_nonce = 32'h0e33337a;
    model_clear();
    idle(3);
    rst = 1'b0;
    idle(2);

    // reset state
    check("reset_txd", {255'd0, txd}, 256'd0);
    check("reset_work_load", {255'd0, work_load}, 256'd0);
    check("reset_midstate", work_midstate, m_mid);
    check("reset_data", work_data, m_data);
    check_status("reset");

    // known frame
    for (int i = 0; i < 32; i++) send_byte(c_mid[255-8*i -: 8]);
    for (int i = 0; i < 32; i++) send_byte(c_data[255-8*i -: 8]);
    frame_strobe();
    check("known_midstate", work_midstate, c_mid);
    check("known_data", work_data, c_data);

    // random full frame commits
    send_random_bytes(64);
    frame_strobe();

    // short frame: discarded
    send_random_bytes(63);
    frame_strobe();
    check("short_mid_kept", work_midstate, m_mid);
    check("short_data_kept", work_data, m_data);

    // partial byte: discarded
    send_random_bytes(10);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    frame_strobe();
    check("partial_mid_kept", work_midstate, m_mid);

    // long frame: overrun, discarded
    send_random_bytes(65);
    frame_strobe();
    check("long_mid_kept", work_midstate, m_mid);
    check_status("overrun");

    // a good frame after an overrun still commits
    send_random_bytes(64);
    frame_strobe();

    // single known nonce, then empty poll
    push_nonce(c_nonce);
    check_status("one_nonce");
    polls(37);
    check_status("one_nonce_drained");

    // five pushes without reads
    for (int i = 0; i < 5; i++) push_nonce($urandom);
    check_status("five_push");
    polls(4 * 36 + 1);
    check_status("five_push_drained");

    // full FIFO with a push coinciding with the final-bit pop
    do_reset();
    for (int i = 0; i < 4; i++) push_nonce($urandom);
    polls(35);
    poll(1'b1, $urandom);
    check_status("coincident");
    polls(4 * 36 + 1);
    check_status("coincident_drained");

    // reset in the middle of a nonce
    push_nonce($urandom);
    polls(18);
    do_reset();
    check("midtx_reset_txd", {255'd0, txd}, 256'd0);
    check_status("midtx_reset");
    polls(1);

    idle(10);
    check("tx_scoreboard_empty", 256'(exp_tx.size()), 256'd0);
    check("work_scoreboard_empty", 256'(exp_mid.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
